// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter sharing one DDR3 AXI read port between two requesters.
// An order FIFO records each grant so that in-order read bursts can be steered back.
module ddr3_rd_arbiter #(
  parameter int ADDRS = 27,
  parameter int REQID = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             mclk,
  input  logic             arst_n,

  input  logic             s0_arvalid_i,
  output logic             s0_arready_o,
  input  logic [ADDRS-1:0] s0_araddr_i,
  input  logic [REQID-1:0] s0_arid_i,
  input  logic [7:0]       s0_arlen_i,
  input  logic [1:0]       s0_arburst_i,
  output logic             s0_rvalid_o,
  input  logic             s0_rready_i,
  output logic             s0_rlast_o,
  output logic [1:0]       s0_rresp_o,
  output logic [REQID-1:0] s0_rid_o,
  output logic [WIDTH-1:0] s0_rdata_o,

  input  logic             s1_arvalid_i,
  output logic             s1_arready_o,
  input  logic [ADDRS-1:0] s1_araddr_i,
  input  logic [REQID-1:0] s1_arid_i,
  input  logic [7:0]       s1_arlen_i,
  input  logic [1:0]       s1_arburst_i,
  output logic             s1_rvalid_o,
  input  logic             s1_rready_i,
  output logic             s1_rlast_o,
  output logic [1:0]       s1_rresp_o,
  output logic [REQID-1:0] s1_rid_o,
  output logic [WIDTH-1:0] s1_rdata_o,

  output logic             m_arvalid_o,
  input  logic             m_arready_i,
  output logic [ADDRS-1:0] m_araddr_o,
  output logic [REQID-1:0] m_arid_o,
  output logic [7:0]       m_arlen_o,
  output logic [1:0]       m_arburst_o,
  input  logic             m_rvalid_i,
  output logic             m_rready_o,
  input  logic             m_rlast_i,
  input  logic [1:0]       m_rresp_i,
  input  logic [REQID-1:0] m_rid_i,
  input  logic [WIDTH-1:0] m_rdata_i,

  output logic [4:0]       pending_o,
  output logic             err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshakes: a transfer happens in a cycle where valid && ready are both high;
  // a source holding valid keeps its payload stable until that cycle.

  logic             m_arvalid_q, m_arvalid_d;
  logic [ADDRS-1:0] m_araddr_q, m_araddr_d;
  logic [REQID-1:0] m_arid_q, m_arid_d;
  logic [7:0]       m_arlen_q, m_arlen_d;
  logic [1:0]       m_arburst_q, m_arburst_d;
  logic             rr_q, rr_d;
  logic [DEPTH-1:0] ord_q, ord_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic ar_free, accept, win, nonempty, head, pop;

  always_comb begin
    ar_free  = !m_arvalid_q || m_arready_i;
    // Count is compared without lookahead: a pop while full frees a slot next cycle.
    accept   = arst_n && ar_free && (cnt_q < 5'(DEPTH)) && (s0_arvalid_i || s1_arvalid_i);
    win      = s1_arvalid_i && (!s0_arvalid_i || rr_q);
    nonempty = (cnt_q != 5'd0);
    head     = ord_q[rd_ptr_q];
  end

  assign s0_arready_o = accept && !win;
  assign s1_arready_o = accept && win;

  assign m_rready_o  = nonempty && (head ? s1_rready_i : s0_rready_i);
  assign s0_rvalid_o = m_rvalid_i && nonempty && !head;
  assign s1_rvalid_o = m_rvalid_i && nonempty && head;
  assign pop         = m_rvalid_i && m_rready_o && m_rlast_i;

  assign s0_rlast_o = m_rlast_i;
  assign s0_rresp_o = m_rresp_i;
  assign s0_rid_o   = m_rid_i;
  assign s0_rdata_o = m_rdata_i;
  assign s1_rlast_o = m_rlast_i;
  assign s1_rresp_o = m_rresp_i;
  assign s1_rid_o   = m_rid_i;
  assign s1_rdata_o = m_rdata_i;

  assign m_arvalid_o = m_arvalid_q;
  assign m_araddr_o  = m_araddr_q;
  assign m_arid_o    = m_arid_q;
  assign m_arlen_o   = m_arlen_q;
  assign m_arburst_o = m_arburst_q;
  assign pending_o   = cnt_q;
  assign err_o       = err_q;

  always_comb begin
    m_arvalid_d = m_arvalid_q;
    m_araddr_d  = m_araddr_q;
    m_arid_d    = m_arid_q;
    m_arlen_d   = m_arlen_q;
    m_arburst_d = m_arburst_q;
    rr_d        = rr_q;
    ord_d       = ord_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q || (m_rvalid_i && !nonempty);

    if (accept) begin
      m_arvalid_d     = 1'b1;
      m_araddr_d      = win ? s1_araddr_i  : s0_araddr_i;
      m_arid_d        = win ? s1_arid_i    : s0_arid_i;
      m_arlen_d       = win ? s1_arlen_i   : s0_arlen_i;
      m_arburst_d     = win ? s1_arburst_i : s0_arburst_i;
      rr_d            = !win;
      ord_d[wr_ptr_q] = win;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else if (m_arready_i) begin
      m_arvalid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (accept && !pop) begin
      cnt_d = cnt_q + 5'd1;
    end else if (pop && !accept) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arid_q    <= '0;
      m_arlen_q   <= '0;
      m_arburst_q <= '0;
      rr_q        <= 1'b0;
      ord_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arid_q    <= m_arid_d;
      m_arlen_q   <= m_arlen_d;
      m_arburst_q <= m_arburst_d;
      rr_q        <= rr_d;
      ord_q       <= ord_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Bench for ddr3_rd_arbiter: vector table, directed corner sequences and a
// randomized run checked against a queue-based model of the arbiter.
module tb_ddr3_rd_arbiter;

  localparam int ADDRS = 27;
  localparam int REQID = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             mclk = 1'b0;
  logic             arst_n;
  logic             s0_arvalid_i, s0_arready_o, s0_rvalid_o, s0_rready_i, s0_rlast_o;
  logic [ADDRS-1:0] s0_araddr_i;
  logic [REQID-1:0] s0_arid_i, s0_rid_o;
  logic [7:0]       s0_arlen_i;
  logic [1:0]       s0_arburst_i, s0_rresp_o;
  logic [WIDTH-1:0] s0_rdata_o;
  logic             s1_arvalid_i, s1_arready_o, s1_rvalid_o, s1_rready_i, s1_rlast_o;
  logic [ADDRS-1:0] s1_araddr_i;
  logic [REQID-1:0] s1_arid_i, s1_rid_o;
  logic [7:0]       s1_arlen_i;
  logic [1:0]       s1_arburst_i, s1_rresp_o;
  logic [WIDTH-1:0] s1_rdata_o;
  logic             m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o, m_rlast_i;
  logic [ADDRS-1:0] m_araddr_o;
  logic [REQID-1:0] m_arid_o, m_rid_i;
  logic [7:0]       m_arlen_o;
  logic [1:0]       m_arburst_o, m_rresp_i;
  logic [WIDTH-1:0] m_rdata_i;
  logic [4:0]       pending_o;
  logic             err_o;

  ddr3_rd_arbiter #(.ADDRS(ADDRS), .REQID(REQID), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .mclk(mclk), .arst_n(arst_n),
    .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o), .s0_araddr_i(s0_araddr_i),
    .s0_arid_i(s0_arid_i), .s0_arlen_i(s0_arlen_i), .s0_arburst_i(s0_arburst_i),
    .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i), .s0_rlast_o(s0_rlast_o),
    .s0_rresp_o(s0_rresp_o), .s0_rid_o(s0_rid_o), .s0_rdata_o(s0_rdata_o),
    .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o), .s1_araddr_i(s1_araddr_i),
    .s1_arid_i(s1_arid_i), .s1_arlen_i(s1_arlen_i), .s1_arburst_i(s1_arburst_i),
    .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i), .s1_rlast_o(s1_rlast_o),
    .s1_rresp_o(s1_rresp_o), .s1_rid_o(s1_rid_o), .s1_rdata_o(s1_rdata_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rlast_i(m_rlast_i),
    .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i),
    .pending_o(pending_o), .err_o(err_o)
  );

  // ---------------- clock ----------------
  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  bit rnd_fields = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding bursts are a plain queue of port numbers; the AR register is a record.
  int               ord_m[$];
  bit               rr_m, arv_m, err_m;
  logic [ADDRS-1:0] addr_m;
  logic [REQID-1:0] id_m;
  logic [7:0]       len_m;
  logic [1:0]       burst_m;

  function automatic void model_reset();
    ord_m.delete();
    rr_m = 0; arv_m = 0; err_m = 0;
    addr_m = '0; id_m = '0; len_m = '0; burst_m = '0;
  endfunction

  // Compare every output against the model for the current inputs, then advance the model.
  task automatic model_step();
    bit accept, winner, nonempty, rdy;
    int h;
    bit can_take = (!arv_m || m_arready_i) && (ord_m.size() < DEPTH);
    accept = can_take && (s0_arvalid_i || s1_arvalid_i);
    if (s0_arvalid_i && s1_arvalid_i) winner = rr_m;
    else                              winner = s1_arvalid_i;
    nonempty = ord_m.size() > 0;
    h = nonempty ? ord_m[0] : 0;
    rdy = nonempty && ((h == 1) ? s1_rready_i : s0_rready_i);

    chk("m_s0_arready", s0_arready_o, accept && winner == 0);
    chk("m_s1_arready", s1_arready_o, accept && winner == 1);
    chk("m_arvalid", m_arvalid_o, arv_m);
    if (arv_m) begin
      chk("m_araddr", m_araddr_o, addr_m);
      chk("m_arid", m_arid_o, id_m);
      chk("m_arlen", m_arlen_o, len_m);
      chk("m_arburst", m_arburst_o, burst_m);
    end
    chk("m_pending", pending_o, ord_m.size());
    chk("m_err", err_o, err_m);
    chk("m_rready", m_rready_o, rdy);
    chk("m_s0_rvalid", s0_rvalid_o, m_rvalid_i && nonempty && h == 0);
    chk("m_s1_rvalid", s1_rvalid_o, m_rvalid_i && nonempty && h == 1);
    chk("m_rdata", {s0_rdata_o, s1_rdata_o}, {m_rdata_i, m_rdata_i});
    chk("m_rfields", {s0_rlast_o, s0_rresp_o, s0_rid_o, s1_rlast_o, s1_rresp_o, s1_rid_o},
        {m_rlast_i, m_rresp_i, m_rid_i, m_rlast_i, m_rresp_i, m_rid_i});

    if (m_rvalid_i && !nonempty) err_m = 1;
    if (m_rvalid_i && rdy && m_rlast_i) void'(ord_m.pop_front());
    if (accept) begin
      arv_m   = 1;
      addr_m  = winner ? s1_araddr_i  : s0_araddr_i;
      id_m    = winner ? s1_arid_i    : s0_arid_i;
      len_m   = winner ? s1_arlen_i   : s0_arlen_i;
      burst_m = winner ? s1_arburst_i : s0_arburst_i;
      rr_m    = !winner;
      ord_m.push_back(int'(winner));
    end else if (m_arready_i) begin
      arv_m = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv(input bit a0, input bit a1, input bit mar, input bit mrv,
                     input bit mrl, input bit rr0, input bit rr1);
    s0_arvalid_i = a0; s1_arvalid_i = a1; m_arready_i = mar;
    m_rvalid_i = mrv; m_rlast_i = mrl; s0_rready_i = rr0; s1_rready_i = rr1;
    m_rdata_i = $urandom(); m_rid_i = 4'($urandom()); m_rresp_i = 2'($urandom());
    if (rnd_fields) begin
      s0_araddr_i = 27'($urandom()); s0_arid_i = 4'($urandom());
      s0_arlen_i = 8'($urandom()); s0_arburst_i = 2'($urandom());
      s1_araddr_i = 27'($urandom()); s1_arid_i = 4'($urandom());
      s1_arlen_i = 8'($urandom()); s1_arburst_i = 2'($urandom());
    end else begin
      s0_araddr_i = 27'h100; s0_arid_i = 4'h1; s0_arlen_i = 8'd3; s0_arburst_i = 2'd1;
      s1_araddr_i = 27'h200; s1_arid_i = 4'h2; s1_arlen_i = 8'd0; s1_arburst_i = 2'd1;
    end
    #2;
  endtask

  task automatic adv();
    model_step();
    @(posedge mclk);
    #2;
  endtask

  // Asynchronous reset with requests and a beat held, to see everything gated off.
  task automatic do_reset();
    arst_n = 1'b0;
    drv(1, 1, 1, 1, 1, 1, 1);
    chk("rst_s0_arready", s0_arready_o, 1'b0);
    chk("rst_s1_arready", s1_arready_o, 1'b0);
    chk("rst_rvalid", {s0_rvalid_o, s1_rvalid_o}, 2'b00);
    chk("rst_m_rready", m_rready_o, 1'b0);
    chk("rst_m_arvalid", m_arvalid_o, 1'b0);
    chk("rst_m_araddr", m_araddr_o, '0);
    chk("rst_pending", pending_o, 5'd0);
    chk("rst_err", err_o, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0);
    @(posedge mclk);
    #2;
    arst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst;
    bit a0, a1, mar, mrv, mrl, rr0, rr1;
    bit e_ar0, e_ar1, e_marv, e_mrr, e_rv0, e_rv1, e_err;
    logic [4:0] e_pend;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(bit rst, bit a0, bit a1, bit mar, bit mrv, bit mrl,
                               bit e_ar0, bit e_ar1, bit e_marv, logic [4:0] e_pend,
                               bit e_mrr, bit e_rv0, bit e_rv1, bit e_err);
    vec_t v;
    v.rst = rst; v.a0 = a0; v.a1 = a1; v.mar = mar; v.mrv = mrv; v.mrl = mrl;
    v.rr0 = 1; v.rr1 = 1;
    v.e_ar0 = e_ar0; v.e_ar1 = e_ar1; v.e_marv = e_marv; v.e_pend = e_pend;
    v.e_mrr = e_mrr; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_err = e_err;
    vt.push_back(v);
  endfunction

  initial begin
    arst_n = 1'b0;
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge mclk);
    #2;
    arst_n = 1'b1;

    //   rst a0 a1 mar mrv mrl | ar0 ar1 marv pend mrr rv0 rv1 err
    // single request from s0, arlen=3: four beats, rlast on the fourth
    addv(0, 1, 0, 1, 0, 0,   1, 0, 0, 5'd0, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 0,   0, 0, 1, 5'd1, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 1, 0,   0, 0, 0, 5'd1, 1, 1, 0, 0);
    addv(0, 0, 0, 1, 1, 0,   0, 0, 0, 5'd1, 1, 1, 0, 0);
    addv(0, 0, 0, 1, 1, 0,   0, 0, 0, 5'd1, 1, 1, 0, 0);
    addv(0, 0, 0, 1, 1, 1,   0, 0, 0, 5'd1, 1, 1, 0, 0);
    addv(0, 0, 0, 1, 0, 0,   0, 0, 0, 5'd0, 0, 0, 0, 0);
    // contention from reset: grants 0,1,0 and bursts steered in grant order
    addv(1, 1, 1, 1, 0, 0,   1, 0, 0, 5'd0, 0, 0, 0, 0);
    addv(0, 1, 1, 1, 0, 0,   0, 1, 1, 5'd1, 1, 0, 0, 0);
    addv(0, 1, 1, 1, 1, 1,   1, 0, 1, 5'd2, 1, 1, 0, 0);
    addv(0, 0, 0, 1, 1, 1,   0, 0, 1, 5'd2, 1, 0, 1, 0);
    addv(0, 0, 0, 1, 1, 1,   0, 0, 0, 5'd1, 1, 1, 0, 0);
    // beat with nothing outstanding: stalls, err sticks
    addv(0, 0, 0, 1, 1, 0,   0, 0, 0, 5'd0, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 0,   0, 0, 0, 5'd0, 0, 0, 0, 1);
    addv(0, 0, 0, 1, 0, 0,   0, 0, 0, 5'd0, 0, 0, 0, 1);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      drv(vt[i].a0, vt[i].a1, vt[i].mar, vt[i].mrv, vt[i].mrl, vt[i].rr0, vt[i].rr1);
      chk($sformatf("v%0d_s0_arready", i), s0_arready_o, vt[i].e_ar0);
      chk($sformatf("v%0d_s1_arready", i), s1_arready_o, vt[i].e_ar1);
      chk($sformatf("v%0d_m_arvalid", i), m_arvalid_o, vt[i].e_marv);
      chk($sformatf("v%0d_pending", i), pending_o, vt[i].e_pend);
      chk($sformatf("v%0d_m_rready", i), m_rready_o, vt[i].e_mrr);
      chk($sformatf("v%0d_rvalid", i), {s0_rvalid_o, s1_rvalid_o}, {vt[i].e_rv0, vt[i].e_rv1});
      chk($sformatf("v%0d_err", i), err_o, vt[i].e_err);
      if (vt[i].e_marv && !vt[i].rst && i == 1)
        chk("v1_m_fields", {m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o},
            {27'h100, 4'h1, 8'd3, 2'd1});
      adv();
    end

    // reset in the middle of a burst clears err, pending and the AR register
    drv(0, 1, 1, 0, 0, 1, 1); adv();
    drv(0, 0, 1, 1, 0, 1, 1);
    chk("mid_pending_pre", pending_o, 5'd1);
    chk("mid_err_pre", err_o, 1'b1);
    adv();
    do_reset();

    // FIFO full: fifth request held off until one pop has registered
    for (int k = 0; k < DEPTH; k++) begin
      drv(1, 0, 1, 0, 0, 1, 1);
      adv();
    end
    drv(1, 0, 1, 0, 0, 1, 1);
    chk("full_s0_arready", s0_arready_o, 1'b0);
    chk("full_pending", pending_o, 5'(DEPTH));
    adv();
    drv(1, 0, 1, 1, 1, 1, 1);
    chk("full_pop_arready", s0_arready_o, 1'b0);
    chk("full_pop_rready", m_rready_o, 1'b1);
    adv();
    drv(1, 0, 1, 0, 0, 1, 1);
    chk("full_after_arready", s0_arready_o, 1'b1);
    chk("full_after_pending", pending_o, 5'(DEPTH - 1));
    adv();

    // AR backpressure: register and grants frozen while m_arready is low
    do_reset();
    drv(1, 0, 1, 0, 0, 1, 1); adv();
    for (int k = 0; k < 5; k++) begin
      drv(1, 1, 0, 0, 0, 1, 1);
      chk("bp_arready", {s0_arready_o, s1_arready_o}, 2'b00);
      chk("bp_m_ar", {m_arvalid_o, m_araddr_o, m_arlen_o}, {1'b1, 27'h100, 8'd3});
      adv();
    end

    // R backpressure: head is s1 and s1 not ready
    do_reset();
    drv(0, 1, 1, 0, 0, 1, 1); adv();
    drv(0, 0, 1, 1, 0, 1, 0);
    chk("rbp_m_rready", m_rready_o, 1'b0);
    chk("rbp_s0_rvalid", s0_rvalid_o, 1'b0);
    chk("rbp_s1_rvalid", s1_rvalid_o, 1'b1);
    adv();

    // randomized run against the model
    rnd_fields = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_rd_arbiter.md
# ddr3_rd_arbiter

Two-port AXI4 read-channel arbiter sharing the single read port (AR/R) of the DDR3 controller between two requesters, e.g. the USB/SPI request engine and a second bus master. Runs entirely in the DDR3 controller clock domain (`mclk`) and sits between the requesters and the controller's AXI read interface. Address requests are granted round-robin, and each grant is recorded in an order FIFO. Read-data bursts are steered back to the requester at the FIFO head. This relies on the controller returning bursts in request order.

## Interface
Parameters:
- `ADDRS`, 27: AXI byte-address width.
- `REQID`, 4: AXI ID width, passed through unchanged.
- `WIDTH`, 32: read-data width.
- `DEPTH`, 4: order-FIFO depth, i.e. the maximum number of outstanding bursts. Power of two, 2..16.

Ports (N in {0,1}):
- `mclk`  in  1  DDR3 controller clock; all logic is on the rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `sN_arvalid_i`  in  1  requester N address valid.
- `sN_arready_o`  out  1  requester N address accepted.
- `sN_araddr_i`  in  ADDRS  requester N address.
- `sN_arid_i`  in  REQID  requester N ID.
- `sN_arlen_i`  in  8  requester N burst length minus 1.
- `sN_arburst_i`  in  2  requester N burst type.
- `sN_rvalid_o`  out  1  data valid to requester N.
- `sN_rready_i`  in  1  requester N data ready.
- `sN_rlast_o`, `sN_rresp_o`[2], `sN_rid_o`[REQID], `sN_rdata_o`[WIDTH]  out  read-data fields to requester N.
- `m_arvalid_o`  out  1  address valid to the controller.
- `m_arready_i`  in  1  controller address ready.
- `m_araddr_o`, `m_arid_o`, `m_arlen_o`, `m_arburst_o`  out  address fields to the controller (same widths as the requester side).
- `m_rvalid_i`  in  1  controller data valid.
- `m_rready_o`  out  1  data ready to the controller.
- `m_rlast_i`, `m_rresp_i`, `m_rid_i`, `m_rdata_i`  in  read-data fields from the controller.
- `pending_o`  out  5  number of outstanding bursts in the order FIFO.
- `err_o`  out  1  sticky flag: an R beat arrived while no burst was outstanding.

## Operation
- **AR output register.** A single register holds `m_ar*`. It is "free" when `!m_arvalid_o || m_arready_i`.
- **Accept condition.** A request is accepted in any cycle where all of the following hold:
  - the output register is free;
  - `pending_o < DEPTH`, using the registered count with no lookahead;
  - at least one `sN_arvalid_i` is high.
- **Arbitration.**
  - `sN_arready_o` is combinational and is high only for the granted N, in the accepting cycle.
  - Round-robin pointer `rr` names the preferred port. If both ports request, the preferred one wins; if only one requests, it wins regardless of `rr`.
  - After each acceptance, `rr` becomes the port that did not win.
- **On acceptance.**
  - The winner's fields load into the `m_ar*` register and `m_arvalid_o` is set to 1.
  - The winner's index is pushed into the order FIFO.
- **AR handshake.** When `m_arready_i` is high with no new acceptance, `m_arvalid_o` is cleared. `m_ar*` never changes while `m_arvalid_o && !m_arready_i`.
- **R steering.** This path is combinational. Let `h` be the FIFO head and `nonempty = pending_o != 0`.
  - `sh_rvalid_o = m_rvalid_i && nonempty`; the other port's `rvalid` is 0.
  - `m_rready_o = nonempty && sh_rready_i`.
  - `rdata`/`rid`/`rresp`/`rlast` are broadcast to both ports; only `rvalid` qualifies them.
- **Pop.** The FIFO head is popped on `m_rvalid_i && m_rready_o && m_rlast_i`.
- **Count update.**
  - `pending_o` increments on push only, decrements on pop only, and is unchanged when a push and a pop occur in the same cycle.
  - A pop with the FIFO full frees a slot only from the next cycle.
- **Empty-FIFO beat.** If `m_rvalid_i` is high while the FIFO is empty, `m_rready_o` stays 0 (the beat stalls) and `err_o` is set. `err_o` clears only on reset.
- **Reset values** (`arst_n` low, asynchronous): `m_arvalid_o=0`, `m_ar*` fields 0, FIFO pointers 0, `pending_o=0`, `rr=0` (port 0 preferred), `err_o=0`.
  - All `sN_arready_o`, `sN_rvalid_o` and `m_rready_o` are 0 while reset is asserted.
  - Reset in the middle of a burst discards all outstanding order entries.

## Timing
- AR latency: 1 cycle from `sN_arvalid_i && sN_arready_o` to `m_arvalid_o`.
- AR throughput: 1 request per cycle while `m_arready_i` is held high and the FIFO is not full.
- R path: 0 cycles of latency and no buffering. A beat is transferred to requester h in the same cycle it is transferred from the controller.
- Reset release: acceptance is possible on the first `mclk` edge after `arst_n` deasserts. Deassertion is synchronised externally.
- `pending_o` and `err_o` are registered and update one cycle after the causing event.

## Test plan
- **Single request:** `s0` requests `araddr=0x100`, `arlen=3`, `m_arready_i=1`.
  - Expect `m_arvalid_o` one cycle later with identical fields, then `pending_o=1`.
  - Four R beats reach `s0` only, `rlast` on the 4th; then `pending_o=0`.
- **Contention:** both ports request continuously with `m_arready_i=1`.
  - Expected grants are 0,1,0,1,… from reset.
  - Returned bursts (`arlen=0`) are steered alternately to `s0` and `s1` in grant order.
- **FIFO full:** `DEPTH=4`, 4 requests accepted, controller withholds R.
  - A 5th request sees `sN_arready_o=0` and `pending_o=4`.
  - After one `rlast` pop, the 5th request is accepted the following cycle.
- **Backpressure:**
  - Holding `m_arready_i=0` for 5 cycles keeps `m_ar*` stable and blocks further acceptances.
  - Holding `s1_rready_i=0` while the head is 1 keeps `m_rready_o=0` and prevents any beat reaching `s0`.
- **Error and reset:**
  - `m_rvalid_i=1` with the FIFO empty gives `m_rready_o=0` and `err_o=1` the next cycle, and `err_o` stays 1.
  - Asserting `arst_n` mid-burst clears `err_o`, `pending_o` and `m_arvalid_o` immediately.
